// File: rtl/mul_writeback_unit_pkg.sv
// Shared widths, state encoding and iteration bound for the iterative multiplier
// and its register-file write-back port.
package mul_writeback_unit_pkg;

  localparam int MUL_WIDTH      = 16;
  localparam int MUL_REG_ADDR_W = 3;
  localparam int ITER_LAST      = MUL_WIDTH - 1;

  // Encoding 2'd3 is unused; the FSM sends it back to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add datapath: multiplicand, multiplier and 2*WIDTH accumulator plus the
// add/shift step, sequenced by load/step strobes from the controlling FSM.
module mul_shift_add_dp #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     op_a_i,
  input  logic [WIDTH-1:0]     op_b_i,
  output logic [2*WIDTH-1:0]   product_next_o
);

  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  // The carry of the upper-half add becomes the new MSB after the right shift.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, mcand_q} & {(WIDTH+1){mplier_q[0]}});
    acc_step = {sum, acc_q[WIDTH-1:1]};
  end

  assign product_next_o = acc_step;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= op_a_i;
      mplier_q <= op_b_i;
      acc_q    <= '0;
    end else if (step_i) begin
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      acc_q    <= acc_step;
    end
  end

endmodule

// File: rtl/mul_writeback_unit.sv
// Iterative 16x16 unsigned multiplier that stalls the pipeline while computing and
// drives the register file's dual write port with the low/high product halves.
module mul_writeback_unit
  import mul_writeback_unit_pkg::*;
#(
  parameter int WIDTH      = MUL_WIDTH,
  parameter int REG_ADDR_W = MUL_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  input  logic [REG_ADDR_W-1:0] dst_low_in,
  input  logic [REG_ADDR_W-1:0] dst_high_in,
  output logic                  busy,
  output logic                  stall,
  output logic                  done,
  output logic [WIDTH-1:0]      data_to_be_written_low,
  output logic [WIDTH-1:0]      data_to_be_written_high,
  output logic [REG_ADDR_W-1:0] reg_dst_low,
  output logic [REG_ADDR_W-1:0] reg_dst_high,
  output logic                  reg_write_low,
  output logic                  reg_write_high,
  output logic [1:0]            dbg_state_o
);

  // Handshake: start is sampled only in IDLE (a request while busy is dropped, not
  // queued); done and the write enables pulse for exactly the one DONE cycle.
  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        count_q;
  logic [REG_ADDR_W-1:0]   dst_low_lat_q, dst_high_lat_q;
  logic [WIDTH-1:0]        data_low_q, data_high_q;
  logic [REG_ADDR_W-1:0]   reg_dst_low_q, reg_dst_high_q;
  logic                    load, step;
  logic [2*WIDTH-1:0]      product_next;

  mul_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk            (clk),
    .reset          (reset),
    .load_i         (load),
    .step_i         (step),
    .op_a_i         (op_a),
    .op_b_i         (op_b),
    .product_next_o (product_next)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (count_q == LAST_CNT) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      count_q        <= '0;
      dst_low_lat_q  <= '0;
      dst_high_lat_q <= '0;
      data_low_q     <= '0;
      data_high_q    <= '0;
      reg_dst_low_q  <= '0;
      reg_dst_high_q <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        count_q        <= '0;
        dst_low_lat_q  <= dst_low_in;
        dst_high_lat_q <= dst_high_in;
      end else if (step) begin
        count_q <= count_q + 1'b1;
      end
      // Write-port data and indices change only on entry to DONE and hold afterwards.
      if (step && (state_d == DONE)) begin
        data_low_q     <= product_next[WIDTH-1:0];
        data_high_q    <= product_next[2*WIDTH-1:WIDTH];
        reg_dst_low_q  <= dst_low_lat_q;
        reg_dst_high_q <= dst_high_lat_q;
      end
    end
  end

  assign busy                    = (state_q != IDLE);
  assign stall                   = busy;
  assign done                    = (state_q == DONE);
  assign reg_write_low           = done;
  // Same destination for both halves: the low half wins the write port.
  assign reg_write_high          = done && (reg_dst_high_q != reg_dst_low_q);
  assign data_to_be_written_low  = data_low_q;
  assign data_to_be_written_high = data_high_q;
  assign reg_dst_low             = reg_dst_low_q;
  assign reg_dst_high            = reg_dst_high_q;
  assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_mul_writeback_unit.sv
// Self-checking bench for mul_writeback_unit: directed and random multiplies with
// a product/destination scoreboard, latency, pulse-width and reset-abort checks.
module tb_mul_writeback_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] op_a, op_b;
  logic [2:0]  dst_low_in, dst_high_in;
  logic        busy, stall, done;
  logic [15:0] data_to_be_written_low, data_to_be_written_high;
  logic [2:0]  reg_dst_low, reg_dst_high;
  logic        reg_write_low, reg_write_high;
  logic [1:0]  dbg_state_o;

  logic [31:0] exp_q[$];
  logic [6:0]  exp_dst_q[$];
  int          n_checks;
  int          n_fail;

  mul_writeback_unit dut (
    .clk                     (clk),
    .reset                   (reset),
    .start                   (start),
    .op_a                    (op_a),
    .op_b                    (op_b),
    .dst_low_in              (dst_low_in),
    .dst_high_in             (dst_high_in),
    .busy                    (busy),
    .stall                   (stall),
    .done                    (done),
    .data_to_be_written_low  (data_to_be_written_low),
    .data_to_be_written_high (data_to_be_written_high),
    .reg_dst_low             (reg_dst_low),
    .reg_dst_high            (reg_dst_high),
    .reg_write_low           (reg_write_low),
    .reg_write_high          (reg_write_high),
    .dbg_state_o             (dbg_state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] dl, input logic [2:0] dh);
    exp_q.push_back(32'(a) * 32'(b));
    exp_dst_q.push_back({(dl != dh), dh, dl});
  endtask

  // Called one negedge after the accepting edge; returns one negedge after done.
  task automatic wait_done(input int exp_lat);
    int          cyc;
    logic [31:0] p;
    logic [6:0]  d;
    logic [15:0] lo, hi;
    cyc = 1;
    while (!done && cyc < 40) begin
      if (!busy || !stall) check("busy_during_run", {30'd0, busy, stall}, 32'd3);
      @(negedge clk);
      cyc++;
    end
    if (!done) begin
      check("done_timeout", {31'd0, done}, 32'd1);
      return;
    end
    check("latency", cyc, exp_lat);
    check("busy_in_done", {30'd0, busy, stall}, 32'd3);
    if (exp_q.size() == 0) begin
      check("unexpected_done", exp_q.size(), 32'd1);
      return;
    end
    p  = exp_q.pop_front();
    d  = exp_dst_q.pop_front();
    lo = data_to_be_written_low;
    hi = data_to_be_written_high;
    check("product", {hi, lo}, p);
    check("dst_low", {29'd0, reg_dst_low}, {29'd0, d[2:0]});
    check("dst_high", {29'd0, reg_dst_high}, {29'd0, d[5:3]});
    check("we_low", {31'd0, reg_write_low}, 32'd1);
    check("we_high", {31'd0, reg_write_high}, {31'd0, d[6]});
    @(negedge clk);
    check("post_done_ctrl", {28'd0, busy, done, reg_write_low, reg_write_high}, 32'd0);
    check("post_done_hold", {data_to_be_written_high, data_to_be_written_low}, {hi, lo});
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] dl, input logic [2:0] dh);
    @(negedge clk);
    op_a = a; op_b = b; dst_low_in = dl; dst_high_in = dh; start = 1'b1;
    push_exp(a, b, dl, dh);
    @(negedge clk);
    start = 1'b0;
    wait_done(17);
  endtask

  initial begin
    int pulses;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; start = 1'b0; op_a = '0; op_b = '0; dst_low_in = '0; dst_high_in = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {26'd0, busy, stall, done, reg_write_low, reg_write_high, 1'b0},
          32'd0);
    check("reset_data", {data_to_be_written_high, data_to_be_written_low}, 32'd0);
    check("reset_dst", {26'd0, reg_dst_high, reg_dst_low}, 32'd0);
    check("reset_state", {30'd0, dbg_state_o}, 32'd0);
    reset = 1'b0;

    run_op(16'd3, 16'd5, 3'd1, 3'd2);
    run_op(16'hFFFF, 16'hFFFF, 3'd3, 3'd6);
    run_op(16'h0000, 16'hBEEF, 3'd0, 3'd7);
    run_op(16'h1234, 16'h0100, 3'd4, 3'd4);

    // start held high: second request is accepted only after DONE; operand noise
    // during RUN must not leak into either product.
    @(negedge clk);
    op_a = 16'd7; op_b = 16'd9; dst_low_in = 3'd5; dst_high_in = 3'd2; start = 1'b1;
    push_exp(16'd7, 16'd9, 3'd5, 3'd2);
    push_exp(16'd7, 16'd9, 3'd5, 3'd2);
    @(negedge clk);
    op_a = 16'(($urandom_range(1, 16'hFFFF))); op_b = 16'hABCD;
    wait_done(17);
    op_a = 16'd7; op_b = 16'd9;
    @(negedge clk);
    op_a = 16'h5555; op_b = 16'h0F0F;
    wait_done(17);
    start = 1'b0;

    // Reset on the 8th RUN cycle aborts without a write pulse.
    @(negedge clk);
    op_a = 16'h00FF; op_b = 16'h00FF; dst_low_in = 3'd1; dst_high_in = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ctrl", {27'd0, busy, stall, done, reg_write_low, reg_write_high}, 32'd0);
    check("abort_data", {data_to_be_written_high, data_to_be_written_low}, 32'd0);
    check("abort_dst", {26'd0, reg_dst_high, reg_dst_low}, 32'd0);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || reg_write_low || reg_write_high || busy) pulses++;
    end
    check("abort_no_activity", pulses, 32'd0);
    run_op(16'h00FF, 16'h00FF, 3'd1, 3'd3);

    for (int i = 0; i < 6; i++) begin
      run_op(16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
    end

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
